mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the memory and the arbiter.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);

  logic [1:0]      dc2arb_command;
  logic [XLEN-1:0] dc2arb_addr;
  logic [63:0]     dc2arb_data;

  logic [1:0]      ic2arb_command;
  logic [XLEN-1:0] ic2arb_addr;

  logic [3:0]      mem2arb_response;
  logic [63:0]     mem2arb_data;
  logic [3:0]      mem2arb_tag;

  logic [1:0]      arb2mem_command;
  logic [XLEN-1:0] arb2mem_addr;
  logic [63:0]     arb2mem_data;

  logic [3:0]      arb2dc_response;
  logic [63:0]     arb2dc_data;
  logic [3:0]      arb2dc_tag;

  logic [3:0]      arb2ic_response;
  logic [63:0]     arb2ic_data;
  logic [3:0]      arb2ic_tag;

  logic [4:0]      outstanding_count;
  logic            tag_error;

  // Arbiter side of the bundle
  modport slave (
    input  dc2arb_command, dc2arb_addr, dc2arb_data,
    input  ic2arb_command, ic2arb_addr,
    input  mem2arb_response, mem2arb_data, mem2arb_tag,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output arb2dc_response, arb2dc_data, arb2dc_tag,
    output arb2ic_response, arb2ic_data, arb2ic_tag,
    output outstanding_count, tag_error
  );

  // Environment side of the bundle (caches plus memory)
  modport master (
    output dc2arb_command, dc2arb_addr, dc2arb_data,
    output ic2arb_command, ic2arb_addr,
    output mem2arb_response, mem2arb_data, mem2arb_tag,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  arb2dc_response, arb2dc_data, arb2dc_tag,
    input  arb2ic_response, arb2ic_data, arb2ic_tag,
    input  outstanding_count, tag_error
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (dcache, icache) with a tag ownership table
// that routes tagged memory returns back to whichever cache issued the load.
module mem_arbiter #(
  parameter int NUM_TAGS = 16
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {
    REQ_DCACHE = 1'b0,
    REQ_ICACHE = 1'b1
  } requester_e;

  requester_e          lastWinner_q, lastWinner_d;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic                tagError_q, tagError_d;
  logic [4:0]          count_q, count_d;

  logic dcActive, icActive, grantDc, grantIc;
  logic accepted, acceptedLoad;
  logic retPresent, retHit, retToIc;

  // Pick the winner: the lone active requester, or the one that did not win last time
  always_comb begin
    dcActive = (bus.dc2arb_command == CMD_LOAD) || (bus.dc2arb_command == CMD_STORE);
    icActive = (bus.ic2arb_command == CMD_LOAD);
    grantDc  = dcActive && (!icActive || (lastWinner_q == REQ_ICACHE));
    grantIc  = icActive && !grantDc;
  end

  // Forward the winner's request to memory and memory's accept tag back to the winner
  always_comb begin
    bus.arb2mem_command = CMD_NONE;
    bus.arb2mem_addr    = '0;
    bus.arb2mem_data    = '0;
    bus.arb2dc_response = '0;
    bus.arb2ic_response = '0;
    if (grantDc) begin
      bus.arb2mem_command = bus.dc2arb_command;
      bus.arb2mem_addr    = bus.dc2arb_addr;
      bus.arb2mem_data    = bus.dc2arb_data;
      bus.arb2dc_response = bus.mem2arb_response;
    end else if (grantIc) begin
      bus.arb2mem_command = CMD_LOAD;
      bus.arb2mem_addr    = bus.ic2arb_addr;
      bus.arb2ic_response = bus.mem2arb_response;
    end
    accepted     = (bus.mem2arb_response != 4'd0) && (grantDc || grantIc);
    acceptedLoad = accepted && (bus.arb2mem_command == CMD_LOAD);
  end

  // Route a tagged memory return to the cache that owns the tag; unknown tags go nowhere
  always_comb begin
    retPresent      = (bus.mem2arb_tag != 4'd0);
    retHit          = retPresent && valid_q[bus.mem2arb_tag];
    retToIc         = owner_q[bus.mem2arb_tag];
    bus.arb2dc_data = '0;
    bus.arb2dc_tag  = '0;
    bus.arb2ic_data = '0;
    bus.arb2ic_tag  = '0;
    if (retHit && !retToIc) begin
      bus.arb2dc_data = bus.mem2arb_data;
      bus.arb2dc_tag  = bus.mem2arb_tag;
    end else if (retHit && retToIc) begin
      bus.arb2ic_data = bus.mem2arb_data;
      bus.arb2ic_tag  = bus.mem2arb_tag;
    end
  end

  // Next table state: retire returned tags first, then record newly accepted loads
  always_comb begin
    valid_d      = valid_q;
    owner_d      = owner_q;
    tagError_d   = tagError_q;
    lastWinner_d = lastWinner_q;
    count_d      = '0;
    if (accepted) begin
      lastWinner_d = grantIc ? REQ_ICACHE : REQ_DCACHE;
    end
    if (retPresent && !retHit) begin
      tagError_d = 1'b1;
    end
    if (retHit) begin
      valid_d[bus.mem2arb_tag] = 1'b0;
    end
    if (acceptedLoad) begin
      if (valid_q[bus.mem2arb_response] &&
          !(retHit && (bus.mem2arb_tag == bus.mem2arb_response))) begin
        tagError_d = 1'b1;
      end
      valid_d[bus.mem2arb_response] = 1'b1;
      owner_d[bus.mem2arb_response] = grantIc;
    end
    for (int i = 0; i < NUM_TAGS; i++) begin
      count_d = count_d + {4'd0, valid_d[i]};
    end
  end

  // State registers; reset forgets every outstanding tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastWinner_q <= REQ_ICACHE;
      valid_q      <= '0;
      owner_q      <= '0;
      tagError_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      lastWinner_q <= lastWinner_d;
      valid_q      <= valid_d;
      owner_q      <= owner_d;
      tagError_q   <= tagError_d;
      count_q      <= count_d;
    end
  end

  assign bus.outstanding_count = count_q;
  assign bus.tag_error         = tagError_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.NUM_TAGS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Drive every environment input to its idle value
  task automatic applyIdle();
    bus.dc2arb_command   = 2'd0;
    bus.dc2arb_addr      = '0;
    bus.dc2arb_data      = '0;
    bus.ic2arb_command   = 2'd0;
    bus.ic2arb_addr      = '0;
    bus.mem2arb_response = '0;
    bus.mem2arb_data     = '0;
    bus.mem2arb_tag      = '0;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset low with idle inputs, leave the bench just after a rising edge
  task automatic applyReset();
    applyIdle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    nextCycle();
  endtask

  // Cleared state while reset is held low
  task automatic test_reset();
    applyIdle();
    reset = 1'b0;
    #3;
    checks++; if (bus.outstanding_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count actual=%0d expected=0", bus.outstanding_count); end
    checks++; if (bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%0b expected=0", bus.tag_error); end
    checks++; if (bus.arb2mem_command !== 2'd0 || bus.arb2mem_addr !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem actual=%0d/%0h expected=0/0", bus.arb2mem_command, bus.arb2mem_addr); end
    applyReset();
  endtask

  // First contest after reset goes to dcache, then icache gets its turn
  task automatic test_first_contest();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'h100;
    bus.ic2arb_command = 2'd1; bus.ic2arb_addr = 32'h200;
    bus.mem2arb_response = 4'd3;
    #1;
    checks++; if (bus.arb2mem_addr !== 32'h100) begin failures++; $display("[TB] FAIL contest_addr actual=%0h expected=100", bus.arb2mem_addr); end
    checks++; if (bus.arb2dc_response !== 4'd3 || bus.arb2ic_response !== 4'd0) begin failures++; $display("[TB] FAIL contest_resp actual=%0d/%0d expected=3/0", bus.arb2dc_response, bus.arb2ic_response); end
    nextCycle();
    checks++; if (bus.outstanding_count !== 5'd1) begin failures++; $display("[TB] FAIL contest_count1 actual=%0d expected=1", bus.outstanding_count); end
    bus.dc2arb_command = 2'd0;
    bus.mem2arb_response = 4'd4;
    #1;
    checks++; if (bus.arb2mem_addr !== 32'h200 || bus.arb2mem_command !== 2'd1) begin failures++; $display("[TB] FAIL contest_ic_addr actual=%0h/%0d expected=200/1", bus.arb2mem_addr, bus.arb2mem_command); end
    checks++; if (bus.arb2ic_response !== 4'd4 || bus.arb2dc_response !== 4'd0) begin failures++; $display("[TB] FAIL contest_ic_resp actual=%0d/%0d expected=4/0", bus.arb2ic_response, bus.arb2dc_response); end
    nextCycle();
    checks++; if (bus.outstanding_count !== 5'd2) begin failures++; $display("[TB] FAIL contest_count2 actual=%0d expected=2", bus.outstanding_count); end
  endtask

  // Load with tag 5 returns two cycles later to dcache only
  task automatic test_return();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'h40;
    bus.mem2arb_response = 4'd5;
    nextCycle();
    checks++; if (bus.outstanding_count !== 5'd1) begin failures++; $display("[TB] FAIL return_count1 actual=%0d expected=1", bus.outstanding_count); end
    applyIdle();
    nextCycle();
    bus.mem2arb_tag = 4'd5; bus.mem2arb_data = 64'd88;
    #1;
    checks++; if (bus.arb2dc_data !== 64'd88 || bus.arb2dc_tag !== 4'd5) begin failures++; $display("[TB] FAIL return_dc actual=%0d/%0d expected=88/5", bus.arb2dc_data, bus.arb2dc_tag); end
    checks++; if (bus.arb2ic_tag !== 4'd0 || bus.arb2ic_data !== 64'd0) begin failures++; $display("[TB] FAIL return_ic actual=%0d/%0d expected=0/0", bus.arb2ic_tag, bus.arb2ic_data); end
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd0 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL return_count0 actual=%0d/%0b expected=0/0", bus.outstanding_count, bus.tag_error); end
  endtask

  // Rejected cycles do not rotate priority; the stalled winner gets the accept
  task automatic test_stall();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'h10;
    bus.ic2arb_command = 2'd1; bus.ic2arb_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.arb2mem_addr !== 32'h10 || bus.arb2dc_response !== 4'd0) begin failures++; $display("[TB] FAIL stall_hold%0d actual=%0h/%0d expected=10/0", i, bus.arb2mem_addr, bus.arb2dc_response); end
      nextCycle();
    end
    bus.mem2arb_response = 4'd7;
    #1;
    checks++; if (bus.arb2dc_response !== 4'd7 || bus.arb2ic_response !== 4'd0) begin failures++; $display("[TB] FAIL stall_accept actual=%0d/%0d expected=7/0", bus.arb2dc_response, bus.arb2ic_response); end
    nextCycle();
    bus.dc2arb_command = 2'd0; bus.mem2arb_response = 4'd0;
    #1;
    checks++; if (bus.arb2mem_addr !== 32'h20 || bus.outstanding_count !== 5'd1) begin failures++; $display("[TB] FAIL stall_next actual=%0h/%0d expected=20/1", bus.arb2mem_addr, bus.outstanding_count); end
  endtask

  // Stores are forwarded but not tracked; their tag coming back is an error; ic STORE is ignored
  task automatic test_store();
    applyReset();
    bus.ic2arb_command = 2'd2; bus.ic2arb_addr = 32'h77;
    bus.mem2arb_response = 4'd6;
    #1;
    checks++; if (bus.arb2mem_command !== 2'd0 || bus.arb2ic_response !== 4'd0) begin failures++; $display("[TB] FAIL store_ic_ignored actual=%0d/%0d expected=0/0", bus.arb2mem_command, bus.arb2ic_response); end
    bus.dc2arb_command = 2'd2; bus.dc2arb_addr = 32'h1; bus.dc2arb_data = 64'd4;
    bus.mem2arb_response = 4'd10;
    #1;
    checks++; if (bus.arb2mem_data !== 64'd4 || bus.arb2mem_command !== 2'd2 || bus.arb2dc_response !== 4'd10) begin failures++; $display("[TB] FAIL store_fwd actual=%0d/%0d/%0d expected=4/2/10", bus.arb2mem_data, bus.arb2mem_command, bus.arb2dc_response); end
    nextCycle();
    checks++; if (bus.outstanding_count !== 5'd0) begin failures++; $display("[TB] FAIL store_count actual=%0d expected=0", bus.outstanding_count); end
    applyIdle();
    bus.mem2arb_tag = 4'd10; bus.mem2arb_data = 64'h99;
    #1;
    checks++; if (bus.arb2dc_tag !== 4'd0 || bus.arb2ic_tag !== 4'd0 || bus.arb2dc_data !== 64'd0) begin failures++; $display("[TB] FAIL store_drop actual=%0d/%0d/%0h expected=0/0/0", bus.arb2dc_tag, bus.arb2ic_tag, bus.arb2dc_data); end
    nextCycle();
    applyIdle();
    checks++; if (bus.tag_error !== 1'b1) begin failures++; $display("[TB] FAIL store_err actual=%0b expected=1", bus.tag_error); end
  endtask

  // Same-cycle return and reissue of one tag hands it to the new owner cleanly
  task automatic test_same_cycle();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'h30;
    bus.mem2arb_response = 4'd3;
    nextCycle();
    bus.dc2arb_command = 2'd0;
    bus.ic2arb_command = 2'd1; bus.ic2arb_addr = 32'h300;
    bus.mem2arb_response = 4'd3;
    bus.mem2arb_tag = 4'd3; bus.mem2arb_data = 64'd88;
    #1;
    checks++; if (bus.arb2dc_data !== 64'd88 || bus.arb2dc_tag !== 4'd3 || bus.arb2ic_tag !== 4'd0) begin failures++; $display("[TB] FAIL same_route actual=%0d/%0d/%0d expected=88/3/0", bus.arb2dc_data, bus.arb2dc_tag, bus.arb2ic_tag); end
    checks++; if (bus.arb2ic_response !== 4'd3) begin failures++; $display("[TB] FAIL same_resp actual=%0d expected=3", bus.arb2ic_response); end
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd1 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL same_state actual=%0d/%0b expected=1/0", bus.outstanding_count, bus.tag_error); end
    bus.mem2arb_tag = 4'd3; bus.mem2arb_data = 64'h11;
    #1;
    checks++; if (bus.arb2ic_tag !== 4'd3 || bus.arb2ic_data !== 64'h11 || bus.arb2dc_tag !== 4'd0) begin failures++; $display("[TB] FAIL same_newowner actual=%0d/%0h/%0d expected=3/11/0", bus.arb2ic_tag, bus.arb2ic_data, bus.arb2dc_tag); end
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd0 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL same_final actual=%0d/%0b expected=0/0", bus.outstanding_count, bus.tag_error); end
  endtask

  // Reissuing a still-valid tag overwrites the owner and flags an error
  task automatic test_overwrite();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.mem2arb_response = 4'd6;
    nextCycle();
    bus.dc2arb_command = 2'd0;
    bus.ic2arb_command = 2'd1; bus.mem2arb_response = 4'd6;
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd1 || bus.tag_error !== 1'b1) begin failures++; $display("[TB] FAIL overwrite_state actual=%0d/%0b expected=1/1", bus.outstanding_count, bus.tag_error); end
    bus.mem2arb_tag = 4'd6; bus.mem2arb_data = 64'h66;
    #1;
    checks++; if (bus.arb2ic_tag !== 4'd6 || bus.arb2dc_tag !== 4'd0) begin failures++; $display("[TB] FAIL overwrite_route actual=%0d/%0d expected=6/0", bus.arb2ic_tag, bus.arb2dc_tag); end
    nextCycle();
    applyIdle();
  endtask

  // Return of one tag and a new request in the same cycle proceed independently
  task automatic test_back_to_back();
    applyReset();
    bus.ic2arb_command = 2'd1; bus.ic2arb_addr = 32'h90; bus.mem2arb_response = 4'd9;
    nextCycle();
    bus.ic2arb_command = 2'd0;
    bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'h50; bus.mem2arb_response = 4'd2;
    bus.mem2arb_tag = 4'd9; bus.mem2arb_data = 64'h55;
    #1;
    checks++; if (bus.arb2ic_data !== 64'h55 || bus.arb2ic_tag !== 4'd9 || bus.arb2dc_tag !== 4'd0) begin failures++; $display("[TB] FAIL b2b_route actual=%0h/%0d/%0d expected=55/9/0", bus.arb2ic_data, bus.arb2ic_tag, bus.arb2dc_tag); end
    checks++; if (bus.arb2dc_response !== 4'd2 || bus.arb2mem_addr !== 32'h50) begin failures++; $display("[TB] FAIL b2b_req actual=%0d/%0h expected=2/50", bus.arb2dc_response, bus.arb2mem_addr); end
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd1 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL b2b_count actual=%0d/%0b expected=1/0", bus.outstanding_count, bus.tag_error); end
  endtask

  // Fill every usable tag, then drain them all
  task automatic test_full_table();
    applyReset();
    for (int t = 1; t < 16; t++) begin
      bus.dc2arb_command = 2'd1; bus.dc2arb_addr = 32'(t); bus.mem2arb_response = 4'(t);
      nextCycle();
    end
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd15 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL full_count actual=%0d/%0b expected=15/0", bus.outstanding_count, bus.tag_error); end
    for (int t = 1; t < 16; t++) begin
      bus.mem2arb_tag = 4'(t);
      nextCycle();
    end
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd0 || bus.tag_error !== 1'b0) begin failures++; $display("[TB] FAIL drain_count actual=%0d/%0b expected=0/0", bus.outstanding_count, bus.tag_error); end
  endtask

  // Asynchronous reset mid-cycle discards outstanding tags
  task automatic test_reset_mid();
    applyReset();
    bus.dc2arb_command = 2'd1; bus.mem2arb_response = 4'd1;
    nextCycle();
    bus.dc2arb_command = 2'd0;
    bus.ic2arb_command = 2'd1; bus.mem2arb_response = 4'd2;
    nextCycle();
    bus.ic2arb_command = 2'd0;
    bus.dc2arb_command = 2'd1; bus.mem2arb_response = 4'd11;
    nextCycle();
    applyIdle();
    checks++; if (bus.outstanding_count !== 5'd3) begin failures++; $display("[TB] FAIL mid_count3 actual=%0d expected=3", bus.outstanding_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.outstanding_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_async actual=%0d expected=0", bus.outstanding_count); end
    @(posedge clock);
    #2 reset = 1'b1;
    nextCycle();
    bus.mem2arb_tag = 4'd2; bus.mem2arb_data = 64'h22;
    #1;
    checks++; if (bus.arb2ic_tag !== 4'd0 || bus.arb2dc_tag !== 4'd0) begin failures++; $display("[TB] FAIL mid_stale_route actual=%0d/%0d expected=0/0", bus.arb2ic_tag, bus.arb2dc_tag); end
    nextCycle();
    applyIdle();
    checks++; if (bus.tag_error !== 1'b1) begin failures++; $display("[TB] FAIL mid_stale_err actual=%0b expected=1", bus.tag_error); end
  endtask

  // Run every scenario in order and report
  initial begin
    applyIdle();
    test_reset();
    test_first_contest();
    test_return();
    test_stall();
    test_store();
    test_same_cycle();
    test_overwrite();
    test_back_to_back();
    test_full_table();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
